// File: rtl/mcpu_pkg.sv
// Shared MCPU constants and the boot-loader state encoding.
package mcpu_pkg;

  localparam int unsigned WORD_SIZE   = 16;
  localparam int unsigned ADDR_SIZE   = 8;
  localparam int unsigned OPCODE_SIZE = 4;

  typedef enum logic [2:0] {
    S_COUNT,
    S_HI,
    S_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/mcpu_prog_loader.sv
// Boot-time program loader: byte stream (COUNT, HI/LO words, XOR CHK) into MCPU RAM,
// holding the CPU in reset until a load completes with a matching checksum.
module mcpu_prog_loader #(
  parameter int unsigned WORD_SIZE = mcpu_pkg::WORD_SIZE,
  parameter int unsigned ADDR_SIZE = mcpu_pkg::ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  input  logic                 reload,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err
);
  import mcpu_pkg::*;

  localparam int unsigned    CNT_W      = ADDR_SIZE + 1;
  localparam int unsigned    RAM_SIZE   = 2**ADDR_SIZE;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAM_SIZE);

  loader_state_t          r_state;
  loader_state_t          w_next;
  logic [CNT_W-1:0]       r_remaining;
  logic [CNT_W-1:0]       w_count;
  logic [ADDR_SIZE-1:0]   r_addr;
  logic [7:0]             r_hi;
  logic [7:0]             r_chk;
  logic                   w_accept;
  logic                   r_we;
  logic [ADDR_SIZE-1:0]   r_ram_addr;
  logic [WORD_SIZE-1:0]   r_wdata;
  logic                   r_hold;
  logic                   r_done;
  logic                   r_err;

  assign in_ready  = (r_state != S_DONE) && (r_state != S_ERR);
  assign w_accept  = in_valid && in_ready;
  assign w_count   = (in_data == 8'h00) ? FULL_COUNT : CNT_W'(in_data);

  assign ram_we    = r_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_wdata;
  assign cpu_hold  = r_hold;
  assign done      = r_done;
  assign err       = r_err;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_COUNT: if (w_accept) w_next = S_HI;
      S_HI:    if (w_accept) w_next = S_LO;
      S_LO:    if (w_accept) w_next = (r_remaining == CNT_W'(1)) ? S_CHK : S_HI;
      S_CHK:   if (w_accept) w_next = (in_data == r_chk) ? S_DONE : S_ERR;
      S_DONE:  if (reload)   w_next = S_COUNT;
      S_ERR:   if (reload)   w_next = S_COUNT;
      default:               w_next = S_COUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_COUNT;
    else        r_state <= w_next;
  end

  // Status flags are registered from the next state so they change exactly one edge
  // after the deciding byte (or reload) and never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_remaining <= '0;
      r_addr      <= '0;
      r_hi        <= '0;
      r_chk       <= '0;
      r_we        <= 1'b0;
      r_ram_addr  <= '0;
      r_wdata     <= '0;
      r_hold      <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_hold <= (w_next != S_DONE);
      r_done <= (w_next == S_DONE);
      r_err  <= (w_next == S_ERR);
      if (w_accept) begin
        unique case (r_state)
          S_COUNT: begin
            r_remaining <= w_count;
            r_addr      <= '0;
            r_chk       <= '0;
          end
          S_HI: begin
            r_hi  <= in_data;
            r_chk <= r_chk ^ in_data;
          end
          S_LO: begin
            r_chk       <= r_chk ^ in_data;
            r_we        <= 1'b1;
            r_ram_addr  <= r_addr;
            r_wdata     <= {r_hi, in_data};
            r_remaining <= r_remaining - CNT_W'(1);
            // Saturate so a full-RAM load leaves the pointer at the top address.
            r_addr      <= (r_addr == '1) ? r_addr : r_addr + ADDR_SIZE'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcpu_prog_loader.sv
// Self-checking bench for mcpu_prog_loader: table-driven loads plus reset/reload corner sequences.
module tb_mcpu_prog_loader;
  localparam int unsigned AW = 8;
  localparam int unsigned WW = 16;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data  = 8'h00;
  logic          reload   = 1'b0;
  logic          in_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [WW-1:0] ram_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mcpu_prog_loader #(.WORD_SIZE(WW), .ADDR_SIZE(AW)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .reload   (reload),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  logic [23:0] wq[$];
  always @(negedge clk) if (ram_we === 1'b1) wq.push_back({ram_addr, ram_wdata});

  logic [15:0] words[$];
  logic [7:0]  sb[$];

  typedef struct {
    int         n;
    int         pat;
    logic [7:0] flip;
    int         gap;
    bit         noise;
    bit         exp_done;
    bit         exp_err;
  } case_t;

  case_t cases[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference stream: COUNT (256 encodes as 0), big-endian words, XOR of payload bytes.
  task automatic build(input logic [7:0] flip);
    logic [7:0] x = 8'h00;
    sb.delete();
    sb.push_back(8'(words.size()));
    foreach (words[k]) begin
      sb.push_back(words[k][15:8]);
      sb.push_back(words[k][7:0]);
      x = x ^ words[k][15:8] ^ words[k][7:0];
    end
    sb.push_back(x ^ flip);
  endtask

  task automatic send(input int gap, input bit noise, input int nw);
    int          i = 0;
    int          cyc = 0;
    int          limit;
    int          lat_bad = 0;
    int          hold_bad = 0;
    bit          acc;
    bit          pend = 0;
    logic [23:0] pexp = '0;
    limit = sb.size() * 20 + 100;
    while (i < sb.size() && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        if (!(ram_we === 1'b1 && {ram_addr, ram_wdata} === pexp)) lat_bad++;
      end else if (ram_we !== 1'b0) lat_bad++;
      pend = 0;
      if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) hold_bad++;
      in_valid = ($urandom_range(99) >= gap);
      in_data  = sb[i];
      reload   = noise && ($urandom_range(7) == 0);
      acc      = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin
        if (i >= 2 && i % 2 == 0 && i <= 2 * nw) begin
          pend = 1;
          pexp = {8'((i - 2) / 2), sb[i-1], sb[i]};
        end
        i++;
      end
    end
    @(negedge clk);
    if (pend) begin
      if (!(ram_we === 1'b1 && {ram_addr, ram_wdata} === pexp)) lat_bad++;
    end else if (ram_we !== 1'b0) lat_bad++;
    in_valid = 1'b0;
    reload   = 1'b0;
    chk("stream_consumed", i, sb.size());
    chk("write_latency", lat_bad, 0);
    chk("hold_during_load", hold_bad, 0);
  endtask

  task automatic check_writes(input int nw);
    int badw = 0;
    chk("write_count", wq.size(), nw);
    for (int k = 0; k < nw && k < wq.size(); k++)
      if (wq[k] !== {8'(k), words[k]}) badw++;
    chk("write_data", badw, 0);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_done", done, 0);
    chk("reload_err", err, 0);
    chk("reload_hold", cpu_hold, 1);
    chk("reload_ready", in_ready, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb;
    cases[0] = '{3,   0, 8'h00, 0,  0, 1, 0};
    cases[1] = '{3,   0, 8'h01, 0,  0, 0, 1};
    cases[2] = '{256, 1, 8'h00, 0,  0, 1, 0};
    cases[3] = '{3,   0, 8'h00, 50, 0, 1, 0};
    cases[4] = '{1,   2, 8'h00, 30, 1, 1, 0};
    cases[5] = '{17,  2, 8'h80, 50, 1, 0, 1};
    cases[6] = '{255, 2, 8'h00, 10, 0, 1, 0};

    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (cases[c]) begin
      words.delete();
      for (int k = 0; k < cases[c].n; k++) begin
        if (cases[c].pat == 1)      words.push_back(16'(k));
        else if (cases[c].pat == 2) words.push_back(16'($urandom));
      end
      if (cases[c].pat == 0) words = '{16'h1920, 16'h1A64, 16'h1702};
      build(cases[c].flip);
      wq.delete();
      send(cases[c].gap, cases[c].noise, cases[c].n);
      check_writes(cases[c].n);
      chk("case_done", done, cases[c].exp_done);
      chk("case_err", err, cases[c].exp_err);
      chk("case_hold", cpu_hold, !cases[c].exp_done);
      chk("case_ready_low", in_ready, 0);
      do_reload();
    end

    // Reset after second word's HI byte: partial write kept, next stream starts clean.
    words = '{16'h1122, 16'h3344};
    build(8'h00);
    while (sb.size() > 4) void'(sb.pop_back());
    wq.delete();
    send(0, 0, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_addr", ram_addr, 0);
    chk("mid_rst_wdata", ram_wdata, 0);
    chk("mid_rst_hold", cpu_hold, 1);
    chk("mid_rst_flags", {done, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_partial_writes", wq.size(), 1);
    words = '{16'hBEEF};
    build(8'h00);
    wq.delete();
    send(0, 0, 1);
    check_writes(1);
    chk("after_rst_done", done, 1);
    chk("after_rst_hold", cpu_hold, 0);
    do_reload();

    // Error, ignored bytes in S_ERR, reload colliding with a valid byte, then a good load.
    words = '{16'h0A0B};
    build(8'h55);
    send(0, 0, 1);
    chk("err_flag", err, 1);
    chk("err_done", done, 0);
    chk("err_hold", cpu_hold, 1);
    wq.delete();
    rb = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h01;
      if (in_ready !== 1'b0) rb++;
    end
    @(negedge clk);
    reload = 1'b1;
    if (in_ready !== 1'b0) rb++;
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b0;
    chk("err_ready_low", rb, 0);
    chk("err_reload_clear", err, 0);
    chk("err_reload_hold", cpu_hold, 1);
    chk("err_no_writes", wq.size(), 0);
    words = '{16'h0102, 16'h0304};
    build(8'h00);
    send(40, 1, 2);
    check_writes(2);
    chk("reload_load_done", done, 1);
    chk("reload_load_err", err, 0);
    chk("reload_load_hold", cpu_hold, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
